// File: rtl/packet_buf_pkg.sv
// Shared types and defaults for the single-packet buffer.
package packet_buf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 10;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FILL  = 2'd1,
    ST_AVAIL = 2'd2
  } state_e;

endpackage

// File: rtl/packet_buf_ram.sv
// Simple dual-port byte-enable RAM; registered read, 1-cycle latency, read-first on collisions.
// No backpressure: every strobe is serviced in the cycle it is presented.
module packet_buf_ram
  import packet_buf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en && wr_be[b]) begin
        mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  // Non-blocking update above makes a same-address read see the old word.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/packet_buf.sv
// Single-packet buffer: writer fills, wr_done publishes length, reader releases. Read latency 1 (+1 with OUT_REG).
// Writes are refused via wr_ready while a complete packet is held; reads are never stalled.
module packet_buf
  import packet_buf_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  wr_done,
  output logic                  wr_ready,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  pkt_avail,
  output logic [ADDR_W:0]       pkt_len,
  input  logic                  rd_release
);

  localparam int LEN_W = ADDR_W + 1;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   wr_end;
  logic               wr_acc;
  logic [DATA_W-1:0]  ram_rd_data;
  logic               rd_vld1_q;

  assign wr_ready = (state_q == ST_EMPTY) || (state_q == ST_FILL);
  assign wr_acc   = wr_en && wr_ready;
  assign wr_end   = LEN_W'(wr_addr) + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    if (wr_acc && (wr_end > len_q)) begin
      len_d = wr_end;
    end
    case (state_q)
      ST_EMPTY: begin
        if (wr_done)     state_d = ST_AVAIL;
        else if (wr_acc) state_d = ST_FILL;
      end
      ST_FILL: begin
        if (wr_done) state_d = ST_AVAIL;
      end
      ST_AVAIL: begin
        // Release wins over any wr_done/wr_en seen in the same cycle.
        if (rd_release) begin
          state_d = ST_EMPTY;
          len_d   = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        len_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

  assign pkt_avail = (state_q == ST_AVAIL);
  assign pkt_len   = len_q;

  packet_buf_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_be   (wr_be),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld1_q <= 1'b0;
    else        rd_vld1_q <= rd_en;
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic              rd_vld2_q;
      logic [DATA_W-1:0] rd_data2_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_vld2_q  <= 1'b0;
          rd_data2_q <= '0;
        end else begin
          rd_vld2_q <= rd_vld1_q;
          if (rd_vld1_q) rd_data2_q <= ram_rd_data;
        end
      end

      assign rd_valid = rd_vld2_q;
      assign rd_data  = rd_data2_q;
    end else begin : g_noreg
      // RAM output is not reset, so mask it until a post-reset read has landed.
      logic rd_seen_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_seen_q <= 1'b0;
        else if (rd_en) rd_seen_q <= 1'b1;
      end

      assign rd_valid = rd_vld1_q;
      assign rd_data  = rd_seen_q ? ram_rd_data : '0;
    end
  endgenerate

endmodule

// File: doc/packet_buf.md
PACKET_BUF -- requirements
Module: packet_buf

Interface
REQ-001 Parameter DATA_W, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 10, word address width; depth = 2**ADDR_W.
REQ-003 Parameter OUT_REG, default 0, 1 adds an output register stage on read data.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 wr_en  in  1  write strobe.
REQ-007 wr_addr  in  ADDR_W  write word address.
REQ-008 wr_data  in  DATA_W  write data.
REQ-009 wr_be  in  DATA_W/8  byte enables; bit i gates byte i.
REQ-010 wr_done  in  1  end of packet; the same-cycle write is included.
REQ-011 wr_ready  out  1  buffer accepts writes (state EMPTY or FILL).
REQ-012 rd_en  in  1  read strobe.
REQ-013 rd_addr  in  ADDR_W  read word address.
REQ-014 rd_data  out  DATA_W  read data.
REQ-015 rd_valid  out  1  rd_data holds the result of an accepted read.
REQ-016 pkt_avail  out  1  complete packet held (state AVAIL).
REQ-017 pkt_len  out  ADDR_W+1  packet length in words, valid while pkt_avail.
REQ-018 rd_release  in  1  reader frees the buffer.

Function
REQ-019 FSM states: EMPTY, FILL, AVAIL.
- EMPTY->FILL on an accepted write without wr_done.
- EMPTY/FILL->AVAIL on wr_done.
- AVAIL->EMPTY on rd_release.
REQ-020 A write is accepted only when wr_en=1 and wr_ready=1; it updates only bytes with wr_be=1.
- wr_en, wr_done and rd_release have no effect in states where they are not accepted.
REQ-021 Length tracking:
- len register = max(len, wr_addr+1) over accepted writes since EMPTY.
- Width ADDR_W+1, so the full depth (2**ADDR_W) is representable without wrap.
- Cleared on entry to EMPTY.
REQ-022 wr_done with no write ever accepted SHALL enter AVAIL with pkt_len=0.
REQ-023 Reads are accepted in any state and do not depend on the FSM.
- Latency rd_en->rd_data/rd_valid is 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
- rd_valid pulses for one cycle per accepted read.
- rd_data holds its value when rd_en=0.
REQ-024 Write and read to the same address in the same cycle SHALL return the old data (read-first).
REQ-025 In AVAIL, simultaneous wr_done and rd_release SHALL go to EMPTY and drop the wr_done.
REQ-026 In AVAIL, simultaneous wr_en and rd_release SHALL leave memory unchanged and go to EMPTY.

Reset
REQ-027 On rst_n=0:
- state=EMPTY, len=0, wr_ready=1, pkt_avail=0, pkt_len=0, rd_valid=0, rd_data=0, pipeline registers cleared.
- Memory contents are not reset.
REQ-028 Reset asserted mid-packet or mid-read SHALL abort immediately; no rd_valid is issued for reads in flight.

Structure
REQ-029 Package packet_buf_pkg SHALL hold the FSM state enum and default DATA_W/ADDR_W constants.
REQ-030 Storage SHALL be a sub-module packet_buf_ram: simple dual-port, byte-enable, read-first, inferable as block RAM.

Verification
REQ-031 Write 0xDEADBEEF/0xBEEFCAFE/0xCAFEDEAD to addresses 0,1,2 with wr_done on addr 2 -> pkt_avail=1, pkt_len=3; reads of 0..2 return the same words one cycle later (two with OUT_REG=1).
REQ-032 In AVAIL, write 0x12345678 to addr 0 -> ignored; read of 0 returns 0xDEADBEEF; rd_release -> EMPTY, wr_ready=1.
REQ-033 Word 0x11111111, write 0xAABBCCDD with wr_be=0101 -> read returns 0x11BB11DD.
REQ-034 Same-cycle write 0x55555555 and read of addr 1 (old 0x22222222) -> 0x22222222; next read returns 0x55555555.
REQ-035 Write addr 1023 with wr_done (ADDR_W=10) -> pkt_len=1024; wr_done with no writes -> pkt_len=0.
REQ-036 rst_n low during FILL with a read in flight -> EMPTY, pkt_len=0, no rd_valid; the memory word written before reset is still readable.
